// File: rtl/cfu_simd_mac.sv
// Packed-lane SIMD custom function unit with a persistent accumulator.
// Also provides a sequential dot-product MAC that holds the core via stall_o.
module cfu_simd_mac #(
  parameter int XLEN  = 32,
  parameter int LANES = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            stall_o,
  output logic [XLEN-1:0] rslt_o
);

  localparam int LW   = XLEN / LANES;
  localparam int CW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int NSEL = 1 << CW;
  localparam int PW   = 2 * LW + 2;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              u_q, u_d;

  logic              u_in;
  logic              unused_f7;
  logic [XLEN-1:0]   padd_w, padds_w;
  logic [LW-1:0]     a_sel [NSEL];
  logic [LW-1:0]     b_sel [NSEL];
  logic [LW-1:0]     a_cur, b_cur;
  logic [PW-1:0]     mul_a, mul_b, prod;
  logic [XLEN-1:0]   prod_ext;
  logic              stall;
  logic [XLEN-1:0]   rslt;

  assign u_in      = funct7_i[0];
  assign unused_f7 = ^funct7_i[6:1];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LW-1:0] la, lb;
      logic [LW:0]   s;
      assign la = src1_i[gi*LW +: LW];
      assign lb = src2_i[gi*LW +: LW];
      // One extra bit holds the true sum; its relation to the MSB flags overflow.
      assign s  = {~u_in & la[LW-1], la} + {~u_in & lb[LW-1], lb};
      assign padd_w[gi*LW +: LW] = s[LW-1:0];
      always_comb begin
        padds_w[gi*LW +: LW] = s[LW-1:0];
        if (u_in) begin
          if (s[LW]) padds_w[gi*LW +: LW] = '1;
        end else if (s[LW] != s[LW-1]) begin
          padds_w[gi*LW +: LW] = s[LW] ? {1'b1, {(LW-1){1'b0}}} : {1'b0, {(LW-1){1'b1}}};
        end
      end
    end

    for (gi = 0; gi < NSEL; gi++) begin : g_sel
      if (gi < LANES) begin : g_used
        assign a_sel[gi] = a_q[gi*LW +: LW];
        assign b_sel[gi] = b_q[gi*LW +: LW];
      end else begin : g_pad
        assign a_sel[gi] = '0;
        assign b_sel[gi] = '0;
      end
    end

    if (PW >= XLEN) begin : g_trunc
      assign prod_ext = prod[XLEN-1:0];
    end else begin : g_sext
      assign prod_ext = {{(XLEN-PW){prod[PW-1]}}, prod};
    end
  endgenerate

  // The single shared multiplier: operands extended one bit so one signed multiply covers both U modes.
  assign a_cur = a_sel[cnt_q];
  assign b_cur = b_sel[cnt_q];
  assign mul_a = {{(PW-LW){~u_q & a_cur[LW-1]}}, a_cur};
  assign mul_b = {{(PW-LW){~u_q & b_cur[LW-1]}}, b_cur};
  assign prod  = mul_a * mul_b;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    u_d     = u_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    stall   = 1'b0;
    rslt    = '0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          case (funct3_i)
            3'd0: rslt = src1_i | src2_i;
            3'd1: rslt = padd_w;
            3'd2: rslt = padds_w;
            3'd3: begin
              stall   = 1'b1;
              a_d     = src1_i;
              b_d     = src2_i;
              u_d     = u_in;
              sum_d   = acc_q;
              cnt_d   = '0;
              state_d = CALC;
            end
            3'd4: rslt = acc_q;
            3'd5: begin
              rslt  = acc_q;
              acc_d = '0;
            end
            3'd6: begin
              rslt  = acc_q;
              acc_d = src1_i;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (!en_i) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          sum_d = sum_q + prod_ext;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (en_i) begin
          rslt  = sum_q;
          acc_d = sum_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      u_q     <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      u_q     <= u_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Outputs are held quiet for the whole reset pulse, even if en_i is still asserted.
  assign stall_o = rst_ni & stall;
  assign rslt_o  = rst_ni ? rslt : '0;

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Randomised self-checking bench for cfu_simd_mac against a lane-arithmetic reference model.
module tb_cfu_simd_mac;
  localparam int XLEN  = 32;
  localparam int LANES = 4;
  localparam int LW    = XLEN / LANES;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [2:0]      f3 = '0;
  logic [6:0]      f7 = '0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic            stall;
  logic [XLEN-1:0] rslt;
  logic [XLEN-1:0] m_acc = '0;
  logic [XLEN-1:0] got;
  int              n_cmp = 0, n_bad = 0;

  cfu_simd_mac #(.XLEN(XLEN), .LANES(LANES)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .funct3_i(f3), .funct7_i(f7),
    .src1_i(a), .src2_i(b), .stall_o(stall), .rslt_o(rslt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int lane_val(input logic [31:0] v, input int k, input bit u);
    int x;
    x = int'((v >> (k * LW)) & 32'hFF);
    if (!u && x >= 128) x -= 256;
    return x;
  endfunction

  // Reference: plain integer arithmetic per lane; tracks the accumulator in m_acc.
  function automatic void model(input logic [2:0] op, input bit u, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] res, output int stalls);
    longint t;
    int s;
    res = '0;
    stalls = 0;
    case (op)
      3'd0: res = x | y;
      3'd1, 3'd2: begin
        for (int k = 0; k < LANES; k++) begin
          s = lane_val(x, k, u) + lane_val(y, k, u);
          if (op == 3'd2) begin
            if (u) s = (s > 255) ? 255 : s;
            else   s = (s > 127) ? 127 : ((s < -128) ? -128 : s);
          end
          res |= 32'((s & 255) << (k * LW));
        end
      end
      3'd3: begin
        t = longint'(m_acc);
        for (int k = 0; k < LANES; k++) t += longint'(lane_val(x, k, u) * lane_val(y, k, u));
        res = t[31:0];
        m_acc = res;
        stalls = LANES + 1;
      end
      3'd4: res = m_acc;
      3'd5: begin res = m_acc; m_acc = '0; end
      3'd6: begin res = m_acc; m_acc = x; end
      default: res = '0;
    endcase
  endfunction

  task automatic run(input logic [2:0] op, input bit u, input logic [31:0] x,
                     input logic [31:0] y, input string tag, output logic [31:0] res);
    logic [31:0] er;
    int es, st;
    model(op, u, x, y, er, es);
    en = 1'b1; f3 = op; f7 = {6'($urandom), u}; a = x; b = y;
    st = 0;
    @(negedge clk);
    while (stall === 1'b1 && st < 20) begin
      st++;
      @(negedge clk);
    end
    res = rslt;
    $display("op=%0d u=%0d a=%h b=%h -> rslt=%h stalls=%0d (%s)", op, u, x, y, rslt, st, tag);
    check({tag, "_stalls"}, 32'(st), 32'(es));
    check(tag, rslt, er);
    @(posedge clk);
    #1;
    en = 1'b0;
    f3 = 3'($urandom);
  endtask

  task automatic idle_chk();
    a = $urandom; b = $urandom;
    #1;
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_rslt", rslt, 32'd0);
  endtask

  initial begin
    en = 1'b1; f3 = 3'd0; a = 32'hFFFF0000; b = 32'h0000FFFF;
    #1;
    check("rst_stall0", 32'(stall), 32'd0);
    check("rst_rslt0", rslt, 32'd0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_chk();

    run(3'd0, 1'b0, 32'h0F0F0000, 32'h000000F0, "or", got);
    check("or_lit", got, 32'h0F0F00F0);
    idle_chk();
    run(3'd1, 1'b0, 32'h7F800102, 32'h01FF0304, "padd", got);
    check("padd_lit", got, 32'h807F0406);
    run(3'd2, 1'b0, 32'h7F800102, 32'h01FF0304, "padds_s", got);
    check("padds_s_lit", got, 32'h7F800406);
    run(3'd2, 1'b1, 32'hFF000000, 32'h01000000, "padds_u", got);
    check("padds_u_lit", got, 32'hFF000000);

    run(3'd3, 1'b0, 32'h01020304, 32'h05060708, "dot1", got);
    check("dot1_lit", got, 32'h00000046);
    run(3'd4, 1'b0, 32'h0, 32'h0, "rdacc1", got);
    check("rdacc1_lit", got, 32'h00000046);
    run(3'd3, 1'b0, 32'hFFFFFFFF, 32'h02020202, "dot2", got);
    check("dot2_lit", got, 32'h0000003E);
    run(3'd5, 1'b0, 32'h0, 32'h0, "clr1", got);
    run(3'd3, 1'b1, 32'hFFFFFFFF, 32'h02020202, "dot3", got);
    check("dot3_lit", got, 32'h000007F8);

    run(3'd6, 1'b0, 32'hFFFFFFF0, 32'h0, "wracc", got);
    run(3'd3, 1'b0, 32'h00000004, 32'h00000004, "dot_wrap", got);
    check("dot_wrap_lit", got, 32'h00000000);
    run(3'd5, 1'b0, 32'h0, 32'h0, "clr2", got);
    check("clr2_lit", got, 32'h00000000);

    // Abort: drop en_i during the second CALC cycle.
    run(3'd6, 1'b0, 32'h00001234, 32'h0, "wracc_pre_abort", got);
    en = 1'b1; f3 = 3'd3; f7 = 7'd0; a = 32'h01010101; b = 32'h01010101;
    @(posedge clk);
    @(posedge clk);
    #1 en = 1'b0;
    #1;
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rslt", rslt, 32'd0);
    @(posedge clk);
    #1;
    run(3'd4, 1'b0, 32'h0, 32'h0, "abort_rdacc", got);
    check("abort_rdacc_lit", got, 32'h00001234);
    run(3'd3, 1'b0, 32'h01010101, 32'h01010101, "post_abort_dot", got);

    repeat (150) begin
      run(3'($urandom), 1'($urandom), $urandom, $urandom, "rnd", got);
      if ($urandom_range(0, 3) == 0) idle_chk();
    end

    // Asynchronous reset in the middle of CALC.
    en = 1'b1; f3 = 3'd3; f7 = 7'd0; a = 32'h7F7F7F7F; b = 32'h7F7F7F7F;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midcalc_rst_stall", 32'(stall), 32'd0);
    check("midcalc_rst_rslt", rslt, 32'd0);
    en = 1'b0;
    m_acc = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(3'd4, 1'b0, 32'h0, 32'h0, "rst_rdacc", got);
    check("rst_rdacc_lit", got, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
